store_merge_unit: RTL and testbench

- Write-side companion to the CPU's instruction/data fetch path. It executes sw/sh/sb stores into the word-wide, byte-addressed Memoria.
- Word stores are written directly.
- Half-word and byte stores do read-modify-write: fetch the containing word, merge the new bytes, write the word back.
- Sits between ControlUnit (start/size/done handshake) and the Memoria Address/Wr/Datain/Dataout pins, via the Iord mux address path.

---
 rtl/store_merge_unit_if.sv | 28 ++
 rtl/store_merge_unit.sv | 153 +++++++++++++++
 tb/tb_store_merge_unit.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_merge_unit_if.sv
// Bus bundle for store_merge_unit.
// Carries the ControlUnit request/completion handshake (start, size, addr, wdata -> busy, done, err)
// and the Memoria port (mem_addr, mem_wr, mem_datain out; mem_dataout back).
// slave  : the store unit itself.
// master : the environment (ControlUnit side plus the memory that answers reads).
interface store_merge_unit_if;
   logic        start;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_datain;
   logic [31:0] mem_dataout;

   modport master (
      output start, size, addr, wdata, mem_dataout,
      input  busy, done, err, mem_addr, mem_wr, mem_datain
   );

   modport slave (
      input  start, size, addr, wdata, mem_dataout,
      output busy, done, err, mem_addr, mem_wr, mem_datain
   );
endinterface

// File: rtl/store_merge_unit.sv
// Store executor for sw/sh/sb into the word-wide, byte-addressed Memoria.
// Word stores write straight through; half-word and byte stores read the containing word,
// merge the new bytes (little-endian) and write the word back.
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   bus (slave)      - start/size/addr/wdata request, busy/done/err status,
//                      mem_addr/mem_wr/mem_datain to Memoria, mem_dataout from Memoria
// MEM_LAT: cycles from a registered mem_addr to valid mem_dataout (1..7).
// All outputs come straight from flops.
module store_merge_unit #(
   parameter int unsigned MEM_LAT = 1
) (
   input logic               clock,
   input logic               reset,
   store_merge_unit_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

   localparam logic [1:0] SzWord  = 2'b00;
   localparam logic [1:0] SzHalf  = 2'b01;
   localparam logic [1:0] SzByte  = 2'b10;
   localparam logic [2:0] LastCnt = 3'(MEM_LAT - 1);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic [15:0] wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        mem_wr_q, mem_wr_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_datain_q, mem_datain_d;

   logic        req_bad;
   logic [31:0] merged;

   // Reserved size or misaligned half/word request.
   always_comb begin
      unique case (bus.size)
         SzWord:  req_bad = (bus.addr[1:0] != 2'b00);
         SzHalf:  req_bad = bus.addr[0];
         SzByte:  req_bad = 1'b0;
         default: req_bad = 1'b1;
      endcase
   end

   // Overlay the captured store bytes onto the word returned by Memoria.
   always_comb begin
      merged = bus.mem_dataout;
      if (size_q == SzByte) begin
         merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      size_d       = size_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      mem_wr_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_datain_d = mem_datain_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (req_bad) begin
                  // Rejected in place: the memory port is left untouched.
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  mem_addr_d = {bus.addr[31:2], 2'b00};
                  size_d     = bus.size;
                  off_d      = bus.addr[1:0];
                  wdata_d    = bus.wdata[15:0];
                  busy_d     = 1'b1;
                  if (bus.size == SzWord) begin
                     mem_datain_d = bus.wdata;
                     mem_wr_d     = 1'b1;
                     state_d      = StWrite;
                  end else begin
                     cnt_d   = 3'd0;
                     state_d = StRead;
                  end
               end
            end
         end
         StRead: begin
            cnt_d = cnt_q + 3'd1;
            // mem_dataout is valid at the MEM_LAT-th edge after mem_addr was registered.
            if (cnt_q == LastCnt) begin
               mem_datain_d = merged;
               mem_wr_d     = 1'b1;
               state_d      = StWrite;
            end
         end
         StWrite: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 3'd0;
         size_q       <= 2'b00;
         off_q        <= 2'b00;
         wdata_q      <= 16'h0000;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= 32'h0000_0000;
         mem_datain_q <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         size_q       <= size_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_datain_q <= mem_datain_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.mem_wr     = mem_wr_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_datain = mem_datain_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Three store_merge_unit instances (MEM_LAT = 1, 2, 3) share one request stream; each has its
// own memory model whose read data lags the registered address by MEM_LAT-1 clocks.
// Expected writes and completions (with their cycle) are queued when a request is driven and
// checked when the DUT produces them.
module tb_store_merge_unit;
   localparam int NI = 3;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        start;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        busy       [NI];
   logic        done       [NI];
   logic        err        [NI];
   logic        mem_wr     [NI];
   logic [31:0] mem_addr   [NI];
   logic [31:0] mem_datain [NI];
   logic [31:0] mem_dataout[NI];

   logic [31:0] mem     [NI][256];
   logic [31:0] ref_mem [NI][256];
   logic [7:0]  apipe   [NI][3];

   logic        load;
   logic [7:0]  load_idx;
   logic [31:0] load_data;

   int cyc    = 0;
   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      int          inst;
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      int   inst;
      int   cyc;
      logic e;
   } dn_t;

   wr_t wq[$];
   dn_t dq[$];

   for (genvar g = 0; g < NI; g++) begin : g_inst
      store_merge_unit_if u_if ();
      assign u_if.start       = start;
      assign u_if.size        = size;
      assign u_if.addr        = addr;
      assign u_if.wdata       = wdata;
      assign u_if.mem_dataout = mem_dataout[g];
      assign busy[g]          = u_if.busy;
      assign done[g]          = u_if.done;
      assign err[g]           = u_if.err;
      assign mem_wr[g]        = u_if.mem_wr;
      assign mem_addr[g]      = u_if.mem_addr;
      assign mem_datain[g]    = u_if.mem_datain;

      store_merge_unit #(.MEM_LAT(g + 1)) u_dut (
         .clock(clock),
         .reset(reset),
         .bus  (u_if.slave)
      );
   end

   // Memory read data: instance g sees the word addressed g clocks ago.
   always_comb begin
      mem_dataout[0] = mem[0][mem_addr[0][9:2]];
      mem_dataout[1] = mem[1][apipe[1][0]];
      mem_dataout[2] = mem[2][apipe[2][1]];
   end

   always @(posedge clock) begin
      cyc <= cyc + 1;
      for (int g = 0; g < NI; g++) begin
         apipe[g][0] <= mem_addr[g][9:2];
         apipe[g][1] <= apipe[g][0];
         apipe[g][2] <= apipe[g][1];
         if (load) mem[g][load_idx] <= load_data;
         else if (mem_wr[g] === 1'b1) mem[g][mem_addr[g][9:2]] <= mem_datain[g];
      end
   end

   // Output monitor / scoreboard pop.
   always @(negedge clock) begin
      for (int g = 0; g < NI; g++) begin
         int  idx;
         wr_t w;
         dn_t d;
         if (mem_wr[g] === 1'b1) begin
            idx = -1;
            for (int i = 0; i < wq.size(); i++) if (idx < 0 && wq[i].inst == g) idx = i;
            n_vec = n_vec + 1;
            assert (idx >= 0) else begin
               n_miss = n_miss + 1;
               $error("FAIL wr_unexpected inst%0d: mem_wr=1 at cycle %0d, required no write", g, cyc);
            end
            if (idx >= 0) begin
               w = wq[idx];
               wq.delete(idx);
               n_vec = n_vec + 1;
               assert ({cyc, mem_addr[g], mem_datain[g]} === {w.cyc, w.a, w.d}) else begin
                  n_miss = n_miss + 1;
                  $error("FAIL wr inst%0d: cyc/addr/data %0d/%h/%h, required %0d/%h/%h",
                         g, cyc, mem_addr[g], mem_datain[g], w.cyc, w.a, w.d);
               end
            end
         end
         if (done[g] === 1'b1) begin
            idx = -1;
            for (int i = 0; i < dq.size(); i++) if (idx < 0 && dq[i].inst == g) idx = i;
            n_vec = n_vec + 1;
            assert (idx >= 0) else begin
               n_miss = n_miss + 1;
               $error("FAIL done_unexpected inst%0d: done=1 at cycle %0d, required none", g, cyc);
            end
            if (idx >= 0) begin
               d = dq[idx];
               dq.delete(idx);
               n_vec = n_vec + 1;
               assert ({cyc, err[g]} === {d.cyc, d.e}) else begin
                  n_miss = n_miss + 1;
                  $error("FAIL done inst%0d: cyc/err %0d/%b, required %0d/%b",
                         g, cyc, err[g], d.cyc, d.e);
               end
            end
         end else if (err[g] === 1'b1) begin
            n_vec = n_vec + 1;
            assert (done[g] === 1'b1) else begin
               n_miss = n_miss + 1;
               $error("FAIL err_without_done inst%0d: done=%b, required 1", g, done[g]);
            end
         end
      end
   end

   function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [1:0] sz,
                                             input logic [1:0] off, input logic [31:0] wd);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (sz == 2'b10 && b == int'(off)) r[8*b +: 8] = wd[7:0];
         if (sz == 2'b01 && (b / 2) == (int'(off) / 2)) r[8*b +: 8] = wd[8*(b%2) +: 8];
      end
      return r;
   endfunction

   task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clock);
      load      = 1'b1;
      load_idx  = idx;
      load_data = data;
      for (int g = 0; g < NI; g++) ref_mem[g][idx] = data;
      @(posedge clock);
      #1 load = 1'b0;
   endtask

   // Drive one start pulse; 'accept' marks the instances expected to take it.
   task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [NI-1:0] accept);
      int          e0;
      logic        bad;
      logic [31:0] m;
      @(negedge clock);
      start = 1'b1;
      size  = sz;
      addr  = a;
      wdata = wd;
      e0    = cyc + 1;
      bad   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
      for (int g = 0; g < NI; g++) begin
         if (accept[g]) begin
            if (bad) begin
               dq.push_back('{g, e0, 1'b1});
            end else if (sz == 2'b00) begin
               wq.push_back('{g, e0, {a[31:2], 2'b00}, wd});
               ref_mem[g][a[9:2]] = wd;
               dq.push_back('{g, e0 + 1, 1'b0});
            end else begin
               m = merge_ref(ref_mem[g][a[9:2]], sz, a[1:0], wd);
               wq.push_back('{g, e0 + g + 1, {a[31:2], 2'b00}, m});
               ref_mem[g][a[9:2]] = m;
               dq.push_back('{g, e0 + g + 2, 1'b0});
            end
         end
      end
      @(posedge clock);
      #1 start = 1'b0;
      for (int g = 0; g < NI; g++) begin
         if (accept[g] && !bad) begin
            n_vec = n_vec + 1;
            assert (mem_addr[g] === {a[31:2], 2'b00}) else begin
               n_miss = n_miss + 1;
               $error("FAIL mem_addr_e0 inst%0d: %h, required %h", g, mem_addr[g],
                      {a[31:2], 2'b00});
            end
         end
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((wq.size() != 0 || dq.size() != 0 || busy[0] || busy[1] || busy[2]) && n < 40) begin
         @(negedge clock);
         n++;
      end
      repeat (2) @(negedge clock);
      n_vec = n_vec + 1;
      assert (wq.size() == 0 && dq.size() == 0) else begin
         n_miss = n_miss + 1;
         $error("FAIL drain_%s: pending writes/dones %0d/%0d, required 0/0", tag, wq.size(),
                dq.size());
      end
   endtask

   task automatic check_reset_vals(input string tag);
      for (int g = 0; g < NI; g++) begin
         n_vec = n_vec + 1;
         assert ({busy[g], done[g], err[g], mem_wr[g], mem_addr[g], mem_datain[g]} === 68'h0)
         else begin
            n_miss = n_miss + 1;
            $error("FAIL %s inst%0d: busy/done/err/wr/addr/din %b/%b/%b/%b/%h/%h, required all 0",
                   tag, g, busy[g], done[g], err[g], mem_wr[g], mem_addr[g], mem_datain[g]);
         end
      end
   endtask

   task automatic check_const(input logic [7:0] idx, input logic [31:0] want, input string tag);
      for (int g = 0; g < NI; g++) begin
         n_vec = n_vec + 1;
         assert (mem[g][idx] === want) else begin
            n_miss = n_miss + 1;
            $error("FAIL %s inst%0d: mem=%h, required %h", tag, g, mem[g][idx], want);
         end
      end
   endtask

   task automatic check_ref(input logic [7:0] idx, input string tag);
      for (int g = 0; g < NI; g++) begin
         n_vec = n_vec + 1;
         assert (mem[g][idx] === ref_mem[g][idx]) else begin
            n_miss = n_miss + 1;
            $error("FAIL %s inst%0d: mem=%h, required %h", tag, g, mem[g][idx], ref_mem[g][idx]);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      size  = 2'b00;
      addr  = 32'h0;
      wdata = 32'h0;
      load  = 1'b0;
      load_idx  = 8'h0;
      load_data = 32'h0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_vals("reset_state");
      reset = 1'b0;

      // sb into byte 2
      load_word(8'd64, 32'h1122_3344);
      issue(2'b10, 32'h0000_0102, 32'hFFFF_FFAB, 3'b111);
      drain("sb");
      check_const(8'd64, 32'h11AB_3344, "mem_sb");

      // sh upper and lower half
      load_word(8'd64, 32'h1122_3344);
      issue(2'b01, 32'h0000_0102, 32'h0000_BEEF, 3'b111);
      drain("sh_hi");
      check_const(8'd64, 32'hBEEF_3344, "mem_sh_hi");
      load_word(8'd64, 32'h1122_3344);
      issue(2'b01, 32'h0000_0100, 32'h0000_BEEF, 3'b111);
      drain("sh_lo");
      check_const(8'd64, 32'h1122_BEEF, "mem_sh_lo");

      // sw writes straight through
      issue(2'b00, 32'h0000_0104, 32'hDEAD_BEEF, 3'b111);
      drain("sw");
      check_const(8'd65, 32'hDEAD_BEEF, "mem_sw");

      // back-to-back error requests: misaligned sh, misaligned sw, reserved size
      issue(2'b01, 32'h0000_0101, 32'h0000_1234, 3'b111);
      issue(2'b00, 32'h0000_0106, 32'h5555_AAAA, 3'b111);
      issue(2'b11, 32'h0000_0100, 32'h0BAD_0BAD, 3'b111);
      drain("errors");
      check_const(8'd64, 32'h1122_BEEF, "mem_err_64");
      check_const(8'd65, 32'hDEAD_BEEF, "mem_err_65");

      // start during READ is dropped; start in the done cycle (MEM_LAT=1 only) is taken
      load_word(8'd64, 32'h1122_3344);
      issue(2'b10, 32'h0000_0100, 32'h0000_0055, 3'b111);
      issue(2'b10, 32'h0000_0101, 32'h0000_0066, 3'b000);
      @(posedge clock);
      issue(2'b00, 32'h0000_0104, 32'h0BAD_F00D, 3'b001);
      drain("busy_start");
      check_const(8'd64, 32'h1122_3355, "mem_busy_64");
      check_ref(8'd65, "mem_busy_65");

      // reset at E0+1 aborts a sub-word store with no write
      load_word(8'd64, 32'h1122_3344);
      issue(2'b10, 32'h0000_0103, 32'h0000_0077, 3'b000);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_reset_vals("reset_e1");
      @(negedge clock);
      check_reset_vals("reset_e2");
      repeat (6) @(negedge clock);
      check_const(8'd64, 32'h1122_3344, "mem_after_reset");
      issue(2'b00, 32'h0000_0104, 32'hCAFE_F00D, 3'b111);
      drain("sw_after_reset");
      check_const(8'd65, 32'hCAFE_F00D, "mem_sw_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
